// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the writeback result-select encoding.
// Imported by the writeback-stage modules.
package riscv_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_MEM  = 2'b01,
      RES_PC4  = 2'b10,
      RES_RSVD = 2'b11
   } result_src_e;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: combinational, 0-cycle latency from the W-stage inputs.
// The reserved encoding (and any unknown one) yields all-zero, so X never reaches the array.
module wb_result_mux #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [1:0]      result_srcW,
   input  logic [XLEN-1:0] ALU_resultW,
   input  logic [XLEN-1:0] read_dataW,
   input  logic [XLEN-1:0] pcplus4W,
   output logic [XLEN-1:0] resultW
);
   import riscv_pkg::*;

   result_src_e sel;

   assign sel = result_src_e'(result_srcW);

   always_comb begin
      resultW = '0;
      case (sel)
         RES_ALU: resultW = ALU_resultW;
         RES_MEM: resultW = read_dataW;
         RES_PC4: resultW = pcplus4W;
         default: resultW = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, architectural register file with same-cycle write-to-read bypass.
// Single rising-edge design, synchronous active-high reset; WB_TRACE_EN adds a registered write trace.
module wb_regfile #(
   parameter int XLEN            = riscv_pkg::XLEN,
   parameter int NREGS           = 32,
   parameter int ZERO_REG_EN_IDX = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     reg_writeW,
   input  logic [1:0]               result_srcW,
   input  logic [$clog2(NREGS)-1:0] rdW,
   input  logic [XLEN-1:0]          ALU_resultW,
   input  logic [XLEN-1:0]          read_dataW,
   input  logic [XLEN-1:0]          pcplus4W,
   input  logic [$clog2(NREGS)-1:0] rs1D,
   input  logic [$clog2(NREGS)-1:0] rs2D,
   output logic [XLEN-1:0]          rd1D,
   output logic [XLEN-1:0]          rd2D,
`ifdef WB_TRACE_EN
   output logic                     trace_valid,
   output logic [$clog2(NREGS)-1:0] trace_rd,
   output logic [XLEN-1:0]          trace_data,
`endif
   output logic [XLEN-1:0]          resultW
);
   import riscv_pkg::*;

   localparam int                IDX_W    = $clog2(NREGS);
   localparam logic [IDX_W-1:0]  ZERO_IDX = IDX_W'(ZERO_REG_EN_IDX);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            wr_en;

   wb_result_mux #(
      .XLEN (XLEN)
   ) u_result_mux (
      .result_srcW (result_srcW),
      .ALU_resultW (ALU_resultW),
      .read_dataW  (read_dataW),
      .pcplus4W    (pcplus4W),
      .resultW     (resultW)
   );

   // Reset wins over a coincident write, and also kills the bypass while held.
   assign wr_en = reg_writeW && (rdW != ZERO_IDX) && !reset;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[rdW] = resultW;
      end
      regs_d[ZERO_REG_EN_IDX] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd1D = regs_q[rs1D];
      if (rs1D == ZERO_IDX) begin
         rd1D = '0;
      end else if (wr_en && (rdW == rs1D)) begin
         rd1D = resultW;
      end
   end

   always_comb begin
      rd2D = regs_q[rs2D];
      if (rs2D == ZERO_IDX) begin
         rd2D = '0;
      end else if (wr_en && (rdW == rs2D)) begin
         rd2D = resultW;
      end
   end

`ifdef WB_TRACE_EN
   logic             trace_valid_q, trace_valid_d;
   logic [IDX_W-1:0] trace_rd_q,    trace_rd_d;
   logic [XLEN-1:0]  trace_data_q,  trace_data_d;

   always_comb begin
      trace_valid_d = wr_en;
      trace_rd_d    = trace_rd_q;
      trace_data_d  = trace_data_q;
      if (wr_en) begin
         trace_rd_d   = rdW;
         trace_data_d = resultW;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trace_valid_q <= 1'b0;
         trace_rd_q    <= '0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_rd_q    <= trace_rd_d;
         trace_data_q  <= trace_data_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_rd    = trace_rd_q;
   assign trace_data  = trace_data_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed spec scenarios followed by randomized traffic
// checked against an array-based reference model of the register file.
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic        reg_writeW;
   logic [1:0]  result_srcW;
   logic [4:0]  rdW;
   logic [31:0] ALU_resultW;
   logic [31:0] read_dataW;
   logic [31:0] pcplus4W;
   logic [4:0]  rs1D;
   logic [4:0]  rs2D;
   logic [31:0] rd1D;
   logic [31:0] rd2D;
   logic [31:0] resultW;
`ifdef WB_TRACE_EN
   logic        trace_valid;
   logic [4:0]  trace_rd;
   logic [31:0] trace_data;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [32];
   logic        exp_tv;
   logic [4:0]  exp_trd;
   logic [31:0] exp_tdat;

   wb_regfile dut (
      .clk         (clk),
      .reset       (reset),
      .reg_writeW  (reg_writeW),
      .result_srcW (result_srcW),
      .rdW         (rdW),
      .ALU_resultW (ALU_resultW),
      .read_dataW  (read_dataW),
      .pcplus4W    (pcplus4W),
      .rs1D        (rs1D),
      .rs2D        (rs2D),
      .rd1D        (rd1D),
      .rd2D        (rd2D),
`ifdef WB_TRACE_EN
      .trace_valid (trace_valid),
      .trace_rd    (trace_rd),
      .trace_data  (trace_data),
`endif
      .resultW     (resultW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_result(input logic [1:0] src, input logic [31:0] alu,
                                                input logic [31:0] mem, input logic [31:0] pc4);
      case (src)
         2'd0:    return alu;
         2'd1:    return mem;
         2'd2:    return pc4;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] rs, input logic [31:0] res);
      if (rs == 5'd0) return 32'h0;
      if (!reset && reg_writeW && rdW != 5'd0 && rdW == rs) return res;
      return model[rs];
   endfunction

   // Inputs must already be settled; checks combinational outputs, then advances one edge.
   task automatic do_cycle(input string tag);
      logic [31:0] res;
      res = model_result(result_srcW, ALU_resultW, read_dataW, pcplus4W);
      check({tag, "/resultW"}, resultW, res);
      check({tag, "/rd1D"}, rd1D, model_read(rs1D, res));
      check({tag, "/rd2D"}, rd2D, model_read(rs2D, res));
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         exp_tv   = 1'b0;
         exp_trd  = 5'd0;
         exp_tdat = 32'h0;
      end else if (reg_writeW && rdW != 5'd0) begin
         model[rdW] = res;
         exp_tv     = 1'b1;
         exp_trd    = rdW;
         exp_tdat   = res;
      end else begin
         exp_tv = 1'b0;
      end
      #1;
`ifdef WB_TRACE_EN
      check({tag, "/trace_valid"}, {31'h0, trace_valid}, {31'h0, exp_tv});
      check({tag, "/trace_rd"}, {27'h0, trace_rd}, {27'h0, exp_trd});
      check({tag, "/trace_data"}, trace_data, exp_tdat);
`endif
   endtask

   task automatic set_in(input logic rst, input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] r1, input logic [4:0] r2);
      reset = rst; reg_writeW = we; result_srcW = src; rdW = rd;
      ALU_resultW = alu; read_dataW = mem; pcplus4W = pc4; rs1D = r1; rs2D = r2;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_tv = 1'b0; exp_trd = 5'd0; exp_tdat = 32'h0;

      // Reset, then read back zeros
      set_in(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
      repeat (2) @(posedge clk);
      #1;
      // Write attempt while reset held: no bypass, no write
      set_in(1'b1, 1'b1, 2'd0, 5'd5, 32'h1111_2222, 32'h0, 32'h0, 5'd5, 5'd0);
      check("rst_held_nobypass", rd1D, 32'h0);
      check("rst_held_x0", rd2D, 32'h0);
      do_cycle("rst_held");
      set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
      check("reset_rd1", rd1D, 32'h0);
      check("reset_rd2", rd2D, 32'h0);
      check("reset_result", resultW, 32'h0);
      do_cycle("reset");

      // Write / readback
      set_in(1'b0, 1'b1, 2'd0, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0);
      do_cycle("wr3");
      set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
      check("readback_x3", rd1D, 32'hDEAD_BEEF);
      do_cycle("rd3");

      // Same-cycle bypass on both ports
      set_in(1'b0, 1'b1, 2'd1, 5'd7, 32'h0, 32'h1234_5678, 32'h0, 5'd7, 5'd7);
      check("bypass_rd1", rd1D, 32'h1234_5678);
      check("bypass_rd2", rd2D, 32'h1234_5678);
      do_cycle("bypass");

      // x0 protection
      set_in(1'b0, 1'b1, 2'd2, 5'd0, 32'h0, 32'h0, 32'h100, 5'd0, 5'd3);
      check("x0_result", resultW, 32'h100);
      check("x0_read_pre", rd1D, 32'h0);
      do_cycle("x0wr");
      set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7);
      check("x0_read_post", rd1D, 32'h0);
      check("x7_hold", rd2D, 32'h1234_5678);
      do_cycle("x0rd");

      // Reserved encoding writes zero
      set_in(1'b0, 1'b1, 2'd3, 5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 5'd0);
      check("rsvd_result", resultW, 32'h0);
      do_cycle("rsvd");

      // Reset colliding with a write
      set_in(1'b0, 1'b1, 2'd0, 5'd9, 32'h77, 32'h0, 32'h0, 5'd9, 5'd0);
      do_cycle("pre_coll");
      set_in(1'b1, 1'b1, 2'd0, 5'd9, 32'h55, 32'h0, 32'h0, 5'd9, 5'd7);
      do_cycle("coll");
      set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd7);
      check("coll_x9", rd1D, 32'h0);
      check("coll_x7", rd2D, 32'h0);
      do_cycle("post_coll");

`ifdef WB_TRACE_EN
      set_in(1'b0, 1'b1, 2'd0, 5'd4, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd0, 5'd0);
      do_cycle("trace_wr");
      check("trace_valid_hi", {31'h0, trace_valid}, 32'h1);
      check("trace_rd_4", {27'h0, trace_rd}, 32'h4);
      check("trace_data_a5", trace_data, 32'hA5A5_A5A5);
      set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0);
      do_cycle("trace_idle");
      check("trace_valid_lo", {31'h0, trace_valid}, 32'h0);
      check("trace_data_hold", trace_data, 32'hA5A5_A5A5);
`endif

      // Randomized traffic with occasional mid-stream resets
      for (int n = 0; n < 400; n++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         set_in(($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                rd, $urandom, $urandom, $urandom,
                ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
         do_cycle("rand");
      end

      // Final reset: every register must read zero afterwards
      set_in(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      do_cycle("final_rst");
      for (int i = 0; i < 32; i += 2) begin
         set_in(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(i + 1));
         check("final_zero_p1", rd1D, 32'h0);
         check("final_zero_p2", rd2D, 32'h0);
         do_cycle("final_rd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
